// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
//
// Shared types and helpers for the modulo up/down counter family.
//   dir_t          : count direction (DIR_DN / DIR_UP)
//   cnt_word_t     : widest supported count word; narrower counters zero-extend
//                    into it, which is exact for the comparisons and the +/-1
//                    arithmetic done by next_count()
//   next_t         : next_count() result, {count, wrap}
//   prescale_width : prescaler counter width, max(1, $clog2(PRESCALE))
//   next_count     : pure next-state function for one count step
// -----------------------------------------------------------------------------
package mod_counter_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  localparam int CNT_MAX_WIDTH = 64;

  typedef logic [CNT_MAX_WIDTH-1:0] cnt_word_t;

  typedef struct packed {
    cnt_word_t count;
    logic      wrap;
  } next_t;

  function automatic int prescale_width(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

  // One count step. Increment only happens when count < mod_max and decrement
  // only when count > 0, so the result never leaves the operand width.
  function automatic next_t next_count(input cnt_word_t count,
                                       input cnt_word_t mod_max,
                                       input dir_t      dir);
    next_t res;
    res.count = count;
    res.wrap  = 1'b0;
    if (dir == DIR_UP) begin
      if (count == mod_max) begin
        res.count = '0;
        res.wrap  = 1'b1;
      end else if (count > mod_max) begin
        // Out-of-range value (loaded above mod_max): recover without a wrap.
        res.count = '0;
      end else begin
        res.count = count + cnt_word_t'(1);
      end
    end else begin
      if (count == '0) begin
        res.count = mod_max;
        res.wrap  = 1'b1;
      end else if (count > mod_max) begin
        res.count = mod_max;
      end else begin
        res.count = count - cnt_word_t'(1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_updown_counter_prescaler.sv
// -----------------------------------------------------------------------------
// count_prescaler
//
// Divides enabled cycles by PRESCALE. The internal counter runs 0..PRESCALE-1
// on enabled, non-clear cycles and STEP is high on the PRESCALE-th one.
//
// Parameters
//   PRESCALE : enabled cycles per STEP (>= 1); PRESCALE=1 gives STEP=EN&~CLR
// Ports
//   CLK   in  clock, rising edge
//   RST_  in  asynchronous active-low reset, clears the divider
//   EN    in  advance the divider this cycle
//   CLR   in  synchronous clear (a counter load); wins over EN
//   STEP  out combinational step strobe for the counter
// -----------------------------------------------------------------------------
module count_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic CLK,
  input  logic RST_,
  input  logic EN,
  input  logic CLR,
  output logic STEP
);

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    psc_d = psc_q;
    if (CLR) begin
      psc_d = '0;
    end else if (EN) begin
      psc_d = (psc_q == LAST) ? '0 : psc_q + PW'(1);
    end
  end

  // NOTE: the reset is in the sensitivity list, so it acts asynchronously.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      psc_q <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples
      // pre-edge values regardless of block ordering.
      psc_q <= psc_d;
    end
  end

  assign STEP = EN & ~CLR & (psc_q == LAST);

endmodule

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Modulo up/down counter with run-time terminal value, load, terminal-count
// flag for cascading and a registered wrap pulse. Counts over 0..MOD_MAX.
// Optional prescaler compiled in with `define MOD_COUNTER_PRESCALE_EN.
//
// Parameters
//   WIDTH    : count width, 1..64
//   PRESCALE : enabled cycles per count step (prescaler build only)
// Ports
//   CLK      in  clock, rising edge
//   RST_     in  asynchronous active-low reset
//   EN       in  synchronous enable, gates load and count
//   LD       in  synchronous load of DATA (only with EN=1)
//   UP       in  direction, 1 = up, 0 = down
//   DATA     in  load value (taken verbatim, may exceed MOD_MAX)
//   MOD_MAX  in  terminal value
//   COUNT    out registered count
//   TC       out combinational terminal count, reflects live UP / MOD_MAX
//   WRAP     out registered one-cycle pulse after a wrapping step
// -----------------------------------------------------------------------------
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             RST_,
  input  logic             EN,
  input  logic             LD,
  input  logic             UP,
  input  logic [WIDTH-1:0] DATA,
  input  logic [WIDTH-1:0] MOD_MAX,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             WRAP
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             load;
  logic             step;
  dir_t             dir;
  next_t            step_res;

  assign dir  = dir_t'(UP);
  assign load = EN & LD;

`ifdef MOD_COUNTER_PRESCALE_EN
  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .CLK  (CLK),
    .RST_ (RST_),
    .EN   (EN),
    .CLR  (load),
    .STEP (step)
  );
`else
  // Every enabled, non-load cycle is a step; PRESCALE has no effect here.
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign step            = 1'b1;
`endif

  assign step_res = next_count(cnt_word_t'(count_q), cnt_word_t'(MOD_MAX), dir);

  // Upper bits of the widened result are always zero.
  logic unused_step_hi;
  assign unused_step_hi = ^step_res;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = DATA;
    end else if (EN && step) begin
      count_d = step_res.count[WIDTH-1:0];
      wrap_d  = step_res.wrap;
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign COUNT = count_q;
  assign WRAP  = wrap_q;
  assign TC    = (dir == DIR_UP) ? (count_q == MOD_MAX) : (count_q == '0);

endmodule
